// File: rtl/salsa_pkg.sv
// Shared definitions for the salsa core job scheduler: default core timing,
// the per-slot job record, and an index-width helper.
package salsa_pkg;

  localparam int LAT_DEF    = 9;
  localparam int PASSES_DEF = 4;

  // The slot record is sized for the largest supported configuration;
  // instances use the low bits that their parameters need.
  localparam int PASS_W = 8;
  localparam int SRC_W  = 8;
  localparam int TAG_W  = 16;

  typedef struct packed {
    logic              valid;
    logic [PASS_W-1:0] pass;
    logic [SRC_W-1:0]  src;
    logic [TAG_W-1:0]  tag;
  } slot_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/salsa_sched_if.sv
// Requester/scheduler bundle: master is the requester side, slave is the
// scheduler.
interface salsa_sched_if
  import salsa_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int TAGW = 4
);
  localparam int SRCW = idx_w(NREQ);

  logic [NREQ-1:0]      req;
  logic [NREQ*TAGW-1:0] req_tag;
  logic                 flush;
  logic [NREQ-1:0]      gnt;
  logic                 feedback;
  logic                 done;
  logic [SRCW-1:0]      done_src;
  logic [TAGW-1:0]      done_tag;
  logic                 busy;

  modport master (
    output req, req_tag, flush,
    input  gnt, feedback, done, done_src, done_tag, busy
  );

  modport slave (
    input  req, req_tag, flush,
    output gnt, feedback, done, done_src, done_tag, busy
  );
endinterface

// File: rtl/salsa_rr_arb.sv
// Requester arbiter: round-robin when SALSA_SCHED_RR_EN is defined,
// otherwise fixed priority with the lowest index winning.
module salsa_rr_arb
  import salsa_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDXW = idx_w(NREQ)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  input  logic            adv,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] idx
);

  logic [IDXW-1:0] base;
  logic            found;
  int              k;

  // Search starts at the priority pointer and wraps around the requesters.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(base) + i) % NREQ;
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IDXW'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base <= '0;
    end else begin
`ifdef SALSA_SCHED_RR_EN
      if (adv) base <= (int'(idx) + 1 == NREQ) ? '0 : idx + 1'b1;
`else
      if (adv) base <= '0;
`endif
    end
  end

endmodule

// File: rtl/salsa_sched.sv
// Slot scheduler for a recirculating salsa core: LAT job slots visited in
// turn, each job making PASSES trips. Define SALSA_SCHED_RR_EN for
// round-robin arbitration between requesters.
module salsa_sched
  import salsa_pkg::*;
#(
  parameter int LAT    = LAT_DEF,
  parameter int PASSES = PASSES_DEF,
  parameter int NREQ   = 2,
  parameter int TAGW   = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  salsa_sched_if.slave  bus
);

  localparam int PTRW = idx_w(LAT);
  localparam int SRCW = idx_w(NREQ);

  logic [PTRW-1:0] ptr;
  slot_t           slots [LAT];
  slot_t           cur;

  logic            fin;
  logic            recirc;
  logic            issue;
  logic            any_valid;
  logic [NREQ-1:0] arb_gnt;
  logic [SRCW-1:0] arb_idx;
  logic [TAGW-1:0] new_tag;

  assign cur    = slots[ptr];
  assign fin    = cur.valid && (cur.pass == PASS_W'(PASSES - 1));
  assign recirc = cur.valid && !fin;
  // A slot finishing this cycle is reusable immediately.
  assign issue  = reset_n && !bus.flush && !recirc && (|bus.req);

  assign new_tag = bus.req_tag[int'(arb_idx)*TAGW +: TAGW];

  salsa_rr_arb #(
    .NREQ (NREQ),
    .IDXW (SRCW)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (bus.req),
    .adv     (issue),
    .gnt     (arb_gnt),
    .idx     (arb_idx)
  );

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < LAT; i++) any_valid |= slots[i].valid;
  end

  assign bus.gnt      = issue ? arb_gnt : '0;
  assign bus.feedback = recirc;
  assign bus.done     = fin && !bus.flush;
  assign bus.done_src = bus.done ? cur.src[SRCW-1:0] : '0;
  assign bus.done_tag = bus.done ? cur.tag[TAGW-1:0] : '0;
  assign bus.busy     = any_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
      for (int i = 0; i < LAT; i++) slots[i] <= '0;
    end else begin
      ptr <= (ptr == PTRW'(LAT - 1)) ? '0 : ptr + 1'b1;
      if (bus.flush) begin
        for (int i = 0; i < LAT; i++) slots[i].valid <= 1'b0;
      end else if (recirc) begin
        slots[ptr].pass <= cur.pass + 1'b1;
      end else if (issue) begin
        slots[ptr].valid <= 1'b1;
        slots[ptr].pass  <= '0;
        slots[ptr].src   <= SRC_W'(arb_idx);
        slots[ptr].tag   <= TAG_W'(new_tag);
      end else if (fin) begin
        slots[ptr].valid <= 1'b0;
      end
    end
  end

endmodule
